// File: rtl/sgm_frame_sequencer.sv
// sgm_frame_sequencer: raster read sequencer for a stereo SGM core.
// Sends the frame to the core, then forwards the disparities that come back.
// Ports:
//   clk, rst_n               : single clock, synchronous active-low reset
//   start, abort             : frame start request (IDLE only), frame abort
//   mem_rd_en, mem_addr      : frame-buffer read strobe and raster address
//   mem_left/right_data      : read data, sampled on the edge that closes the read cycle
//   left/right_pixel,
//   pixel_valid              : pixel stream to the core, 1 cycle behind mem_rd_en
//   disp_valid, disparity    : disparity stream from the core
//   out_disparity, out_valid,
//   out_last                 : forwarded disparity, strobe, last-pixel marker
//   busy, done               : not-IDLE flag, one-cycle completion pulse
//   timeout_err, overflow_err: sticky error flags
module sgm_frame_sequencer #(
   parameter int unsigned FRAME_WIDTH   = 272,
   parameter int unsigned FRAME_HEIGHT  = 240,
   parameter int unsigned HBLANK        = 4,
   parameter int unsigned DRAIN_TIMEOUT = 4096,
   parameter int unsigned ADDR_W        = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_left_data,
   input  logic [7:0]        mem_right_data,
   output logic [7:0]        left_pixel,
   output logic [7:0]        right_pixel,
   output logic              pixel_valid,
   input  logic              disp_valid,
   input  logic [5:0]        disparity,
   output logic [5:0]        out_disparity,
   output logic              out_valid,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic              overflow_err
);

   localparam int unsigned TOTAL   = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int unsigned BLANK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
   localparam int unsigned DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

   localparam logic [ADDR_W-1:0]  COL_LAST    = ADDR_W'(FRAME_WIDTH - 1);
   localparam logic [ADDR_W-1:0]  ROW_LAST    = ADDR_W'(FRAME_HEIGHT - 1);
   localparam logic [ADDR_W-1:0]  TOTAL_C     = ADDR_W'(TOTAL);
   localparam logic [ADDR_W-1:0]  TOTAL_M1    = ADDR_W'(TOTAL - 1);
   localparam logic [BLANK_W-1:0] BLANK_LAST  = BLANK_W'((HBLANK > 0) ? HBLANK - 1 : 0);
   localparam logic [DRAIN_W-1:0] DRAIN_LIMIT = DRAIN_W'(DRAIN_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FEED  = 3'd1,
      BLANK = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   col_q, col_d;
   logic [ADDR_W-1:0]   row_q, row_d;
   logic [ADDR_W-1:0]   in_count_q, in_count_d;
   logic [ADDR_W-1:0]   out_count_q, out_count_d;
   logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic                mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]          left_pixel_q, left_pixel_d;
   logic [7:0]          right_pixel_q, right_pixel_d;
   logic                pixel_valid_q, pixel_valid_d;
   logic [5:0]          out_disparity_q, out_disparity_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                timeout_err_q, timeout_err_d;
   logic                overflow_err_q, overflow_err_d;

   // Next-state, counter and output computation
   always_comb begin
      state_d         = state_q;
      col_d           = col_q;
      row_d           = row_q;
      in_count_d      = in_count_q;
      out_count_d     = out_count_q;
      blank_cnt_d     = blank_cnt_q;
      drain_cnt_d     = '0;
      mem_rd_en_d     = 1'b0;
      pixel_valid_d   = mem_rd_en_q;
      left_pixel_d    = mem_rd_en_q ? mem_left_data  : 8'd0;
      right_pixel_d   = mem_rd_en_q ? mem_right_data : 8'd0;
      out_disparity_d = 6'd0;
      out_valid_d     = 1'b0;
      out_last_d      = 1'b0;
      timeout_err_d   = timeout_err_q;
      overflow_err_d  = overflow_err_q;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d        = FEED;
               col_d          = '0;
               row_d          = '0;
               in_count_d     = '0;
               out_count_d    = '0;
               mem_rd_en_d    = 1'b1;
               timeout_err_d  = 1'b0;
               overflow_err_d = 1'b0;
            end
         end
         FEED: begin
            // in_count is both the read tally and the next raster address
            in_count_d = ADDR_W'(in_count_q + 1'b1);
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = ADDR_W'(row_q + 1'b1);
               if (row_q == ROW_LAST) begin
                  state_d = DRAIN;
               end else if (HBLANK == 0) begin
                  mem_rd_en_d = 1'b1;
               end else begin
                  state_d     = BLANK;
                  blank_cnt_d = '0;
               end
            end else begin
               col_d       = ADDR_W'(col_q + 1'b1);
               mem_rd_en_d = 1'b1;
            end
         end
         BLANK: begin
            blank_cnt_d = BLANK_W'(blank_cnt_q + 1'b1);
            if (blank_cnt_q == BLANK_LAST) begin
               state_d     = FEED;
               mem_rd_en_d = 1'b1;
            end
         end
         DRAIN: begin
            // silent-cycle counter restarts on every disparity
            if (out_count_q == TOTAL_C) begin
               state_d = DONE;
            end else if (!disp_valid) begin
               drain_cnt_d = DRAIN_W'(drain_cnt_q + 1'b1);
               if (drain_cnt_d == DRAIN_LIMIT) begin
                  state_d       = DONE;
                  timeout_err_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Disparity forwarding; surplus or unexpected disparities are dropped
      if (disp_valid) begin
         if (state_q == IDLE || out_count_q == TOTAL_C) begin
            overflow_err_d = 1'b1;
         end else if (state_q inside {FEED, BLANK, DRAIN}) begin
            out_valid_d     = 1'b1;
            out_disparity_d = disparity;
            out_last_d      = (out_count_q == TOTAL_M1);
            out_count_d     = ADDR_W'(out_count_q + 1'b1);
         end
      end

      // Abort overrides everything and freezes the error flags
      if (abort && state_q != IDLE) begin
         state_d        = IDLE;
         mem_rd_en_d    = 1'b0;
         out_valid_d    = 1'b0;
         out_last_d     = 1'b0;
         out_count_d    = out_count_q;
         timeout_err_d  = timeout_err_q;
         overflow_err_d = overflow_err_q;
      end

      mem_addr_d = in_count_d;
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         col_q           <= '0;
         row_q           <= '0;
         in_count_q      <= '0;
         out_count_q     <= '0;
         blank_cnt_q     <= '0;
         drain_cnt_q     <= '0;
         mem_rd_en_q     <= 1'b0;
         mem_addr_q      <= '0;
         left_pixel_q    <= 8'd0;
         right_pixel_q   <= 8'd0;
         pixel_valid_q   <= 1'b0;
         out_disparity_q <= 6'd0;
         out_valid_q     <= 1'b0;
         out_last_q      <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         timeout_err_q   <= 1'b0;
         overflow_err_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         col_q           <= col_d;
         row_q           <= row_d;
         in_count_q      <= in_count_d;
         out_count_q     <= out_count_d;
         blank_cnt_q     <= blank_cnt_d;
         drain_cnt_q     <= drain_cnt_d;
         mem_rd_en_q     <= mem_rd_en_d;
         mem_addr_q      <= mem_addr_d;
         left_pixel_q    <= left_pixel_d;
         right_pixel_q   <= right_pixel_d;
         pixel_valid_q   <= pixel_valid_d;
         out_disparity_q <= out_disparity_d;
         out_valid_q     <= out_valid_d;
         out_last_q      <= out_last_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         timeout_err_q   <= timeout_err_d;
         overflow_err_q  <= overflow_err_d;
      end
   end

   assign mem_rd_en     = mem_rd_en_q;
   assign mem_addr      = mem_addr_q;
   assign left_pixel    = left_pixel_q;
   assign right_pixel   = right_pixel_q;
   assign pixel_valid   = pixel_valid_q;
   assign out_disparity = out_disparity_q;
   assign out_valid     = out_valid_q;
   assign out_last      = out_last_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign timeout_err   = timeout_err_q;
   assign overflow_err  = overflow_err_q;

endmodule

// File: tb/tb_sgm_frame_sequencer.sv
// Bench for sgm_frame_sequencer on a 4x2 frame, HBLANK=2, DRAIN_TIMEOUT=16.
// Expected behaviour per cycle is derived from the raster timing formula and
// the disparity schedule, not from a replica of the state machine.
module tb_sgm_frame_sequencer;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int HB = 2;
   localparam int DT = 16;
   localparam int AW = 17;
   localparam int N  = W * H;
   localparam int T  = 72;

   logic          clk = 1'b0;
   logic          rst_n, start, abort;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_left_data, mem_right_data, left_pixel, right_pixel;
   logic          pixel_valid, disp_valid;
   logic [5:0]    disparity, out_disparity;
   logic          out_valid, out_last, busy, done, timeout_err, overflow_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int n_disp;
      int delay;
      bit follow;
      int gap_max;
      int abort_addr;
      bit extra;
      int restart;
      int e_reads;
      int e_outs;
      int e_lasts;
      int e_dones;
      bit e_to;
      bit e_of;
   } scen_t;

   always #5 clk = ~clk;

   function automatic logic [7:0] lpix(input int a);
      return 8'(a * 7 + 3);
   endfunction

   function automatic logic [7:0] rpix(input int a);
      return 8'(a) ^ 8'hA5;
   endfunction

   // Read cycle of pixel i, counting the start cycle as 0
   function automatic int rd_cyc(input int i);
      return 1 + i + (i / W) * HB;
   endfunction

   assign mem_left_data  = lpix(int'(mem_addr));
   assign mem_right_data = rpix(int'(mem_addr));

   sgm_frame_sequencer #(
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .HBLANK(HB),
      .DRAIN_TIMEOUT(DT), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_left_data(mem_left_data), .mem_right_data(mem_right_data),
      .left_pixel(left_pixel), .right_pixel(right_pixel), .pixel_valid(pixel_valid),
      .disp_valid(disp_valid), .disparity(disparity),
      .out_disparity(out_disparity), .out_valid(out_valid), .out_last(out_last),
      .busy(busy), .done(done), .timeout_err(timeout_err), .overflow_err(overflow_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({mem_rd_en, mem_addr, left_pixel, right_pixel, pixel_valid,
                  out_disparity, out_valid, out_last, busy, done,
                  timeout_err, overflow_err});
   endfunction

   // One frame: entered and left at a negedge with all inputs idle
   task automatic run_frame(input scen_t s, input string tag);
      bit         dv   [0:T-1];
      logic [5:0] dval [0:T-1];
      int         dcyc [$];
      int c, d_start, done_c, busy_end, to_c, of_c, nreads, ca, last_in_drain;
      int reads, outs, lasts, dones, kidx, pidx;
      bit e_rd, e_pv, e_ov, e_last;
      logic [63:0] ev, av;

      for (int i = 0; i < T; i++) begin
         dv[i]   = 1'b0;
         dval[i] = 6'($urandom);
      end
      c = 0;
      for (int i = 0; i < s.n_disp; i++) begin
         if (s.follow)    c = rd_cyc(i) + s.delay;
         else if (i == 0) c = s.delay;
         else             c = c + 1 + int'($urandom_range(s.gap_max));
         dv[c] = 1'b1;
         dcyc.push_back(c);
      end

      // Expected timeline from the frame rules
      d_start = rd_cyc(N - 1) + 1;
      ca      = -1;
      to_c    = -1;
      of_c    = -1;
      if (s.abort_addr >= 0) begin
         nreads   = s.abort_addr + 1;
         ca       = rd_cyc(s.abort_addr);
         done_c   = -1;
         busy_end = ca;
      end else begin
         nreads = N;
         if (s.n_disp >= N) begin
            done_c = ((dcyc[N-1] + 1 > d_start) ? dcyc[N-1] + 1 : d_start) + 1;
         end else begin
            last_in_drain = -1;
            foreach (dcyc[i]) if (dcyc[i] >= d_start) last_in_drain = dcyc[i];
            done_c = ((last_in_drain >= 0) ? last_in_drain + 1 : d_start) + DT;
            to_c   = done_c;
         end
         busy_end = done_c;
      end
      if (s.extra) begin
         c       = busy_end + 2 + int'($urandom_range(3));
         dv[c]   = 1'b1;
         of_c    = c + 1;
      end

      reads = 0; outs = 0; lasts = 0; dones = 0;
      for (int n = 0; n < T; n++) begin
         if (n > 0) begin
            e_rd = 1'b0; e_pv = 1'b0; e_ov = 1'b0; e_last = 1'b0; pidx = 0; kidx = -1;
            for (int i = 0; i < nreads; i++) begin
               if (rd_cyc(i) == n)     e_rd = 1'b1;
               if (rd_cyc(i) + 1 == n) begin e_pv = 1'b1; pidx = i; end
            end
            foreach (dcyc[k]) if (dcyc[k] == n - 1) kidx = k;
            if (kidx >= 0 && kidx < N && n - 1 >= 1 && n - 1 < busy_end) begin
               e_ov   = 1'b1;
               e_last = (kidx == N - 1);
            end
            ev = 64'({e_rd, e_rd ? AW'(n - 1 - ((n - 1) / (W + HB)) * HB) : AW'(0),
                      e_pv, e_pv ? lpix(pidx) : 8'd0, e_pv ? rpix(pidx) : 8'd0,
                      e_ov, e_ov ? dval[n-1] : 6'd0, e_last,
                      (n <= busy_end), (n == done_c),
                      (to_c >= 0 && n >= to_c), (of_c >= 0 && n >= of_c)});
            av = 64'({mem_rd_en, e_rd ? mem_addr : AW'(0),
                      pixel_valid, e_pv ? left_pixel : 8'd0, e_pv ? right_pixel : 8'd0,
                      out_valid, e_ov ? out_disparity : 6'd0, e_ov ? out_last : 1'b0,
                      busy, done, timeout_err, overflow_err});
            check($sformatf("%s.cyc%0d", tag, n), av, ev);
            reads += int'(mem_rd_en);
            outs  += int'(out_valid);
            lasts += int'(out_last);
            dones += int'(done);
         end
         start      = (n == 0) || (s.restart > 0 && n == s.restart);
         abort      = (n == ca);
         disp_valid = dv[n];
         disparity  = dval[n];
         @(negedge clk);
      end
      start = 1'b0; abort = 1'b0; disp_valid = 1'b0; disparity = 6'd0;

      check({tag, ".reads"}, 64'(reads), 64'(s.e_reads));
      check({tag, ".outs"},  64'(outs),  64'(s.e_outs));
      check({tag, ".lasts"}, 64'(lasts), 64'(s.e_lasts));
      check({tag, ".dones"}, 64'(dones), 64'(s.e_dones));
      check({tag, ".timeout_err"},  64'(timeout_err),  64'(s.e_to));
      check({tag, ".overflow_err"}, 64'(overflow_err), 64'(s.e_of));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      scen_t tbl [6];
      scen_t rs;

      //          n  dly fol gap abort ext rst  reads outs last done to of
      tbl[0] = '{8,  5,  1,  0,  -1,   0,  2,   8,    8,   1,   1,   0, 0};
      tbl[1] = '{8,  5,  1,  0,  -1,   1,  0,   8,    8,   1,   1,   0, 1};
      tbl[2] = '{0,  1,  0,  0,   3,   0,  0,   4,    0,   0,   0,   0, 0};
      tbl[3] = '{8,  1,  1,  0,  -1,   0,  3,   8,    8,   1,   1,   0, 0};
      tbl[4] = '{8,  12, 1,  0,  -1,   0,  0,   8,    8,   1,   1,   0, 0};
      tbl[5] = '{7,  5,  1,  0,  -1,   0,  0,   8,    7,   0,   1,   1, 0};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; disp_valid = 1'b0; disparity = 6'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // start together with abort in IDLE must not launch a frame
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("start_abort_idle.%0d", i), 64'({busy, mem_rd_en}), 64'd0);
         @(negedge clk);
      end

      for (int r = 0; r < 6; r++) run_frame(tbl[r], $sformatf("row%0d", r));

      // Reset while in BLANK, then confirm the frame does not resume
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("blank_entry", 64'({busy, mem_rd_en}), 64'(2'b10));
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_in_blank", all_outs(), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("no_resume.%0d", i), 64'({busy, mem_rd_en, pixel_valid}), 64'd0);
      end
      run_frame(tbl[0], "after_reset");

      for (int r = 0; r < 8; r++) begin
         rs.n_disp     = N - int'($urandom_range(2));
         rs.delay      = 1 + int'($urandom_range(3));
         rs.follow     = 1'b0;
         rs.gap_max    = int'($urandom_range(2));
         rs.abort_addr = -1;
         rs.extra      = 1'($urandom_range(1));
         rs.restart    = 3;
         rs.e_reads    = N;
         rs.e_outs     = rs.n_disp;
         rs.e_lasts    = (rs.n_disp == N) ? 1 : 0;
         rs.e_dones    = 1;
         rs.e_to       = (rs.n_disp < N);
         rs.e_of       = rs.extra;
         run_frame(rs, $sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
